// File: rtl/matrix_mem_pkg.sv
// ----------------------------------------------------------------------------
// matrix_mem_pkg
// Shared definitions for the operand-matrix block RAMs that feed the
// outer-product multiplier.
//   - default word/address widths
//   - write_mode_e : douta behaviour on a write cycle
//   - init_sel_e   : which power-up image a RAM instance carries
//   - MAT_A_INIT / MAT_B_INIT : 16 x 8-bit power-up images. The 3x3 matrix
//     sits at addresses 1..9 in row-major order; everything else is zero.
// ----------------------------------------------------------------------------
package matrix_mem_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;
    localparam int MAT_DEPTH  = 16;

    typedef enum logic [1:0] {
        WRITE_FIRST = 2'd0,
        READ_FIRST  = 2'd1,
        NO_CHANGE   = 2'd2
    } write_mode_e;

    typedef enum logic [1:0] {
        INIT_MAT_A = 2'd0,
        INIT_MAT_B = 2'd1,
        INIT_ZERO  = 2'd2
    } init_sel_e;

    typedef logic [MAT_DEPTH-1:0][7:0] mat_image_t;

    // Packed concatenations list the highest address first.
    localparam mat_image_t MAT_A_INIT = {
        8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
        8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1,
        8'd0
    };

    localparam mat_image_t MAT_B_INIT = {
        8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
        8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9,
        8'd0
    };

    // Power-up byte for one address of the selected image.
    function automatic logic [7:0] init_byte(init_sel_e sel, int idx);
        logic [7:0] b;
        b = 8'd0;
        if (idx >= 0 && idx < MAT_DEPTH) begin
            case (sel)
                INIT_MAT_A: b = MAT_A_INIT[idx];
                INIT_MAT_B: b = MAT_B_INIT[idx];
                default:    b = 8'd0;
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/bram_out_reg.sv
// ----------------------------------------------------------------------------
// bram_out_reg
// Optional second output stage of the block RAM. Advances only while the
// port is enabled and clears asynchronously with the RAM reset.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low clear
//   en     in  stage enable (port ena)
//   d      in  first-stage read data
//   q      out registered read data
// ----------------------------------------------------------------------------
module bram_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_d;
    logic [W-1:0] q_q;

    // Hold the current value unless the port is enabled this cycle.
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = d;
        end
    end

    // Output stage storage; reset clears it immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/matrix_bram_sp.sv
// ----------------------------------------------------------------------------
// matrix_bram_sp
// Single-port synchronous block RAM holding one 3x3 8-bit operand matrix
// (addresses 1..9, row-major) for the outer-product multiplier. Also usable
// as a general scratch RAM through its write port.
// Parameters:
//   DATA_W       word width
//   ADDR_W       address width, depth = 2**ADDR_W
//   READ_LATENCY 1 or 2 (2 adds an ena-qualified output register;
//                any value other than 2 builds the single-stage version)
//   WRITE_MODE   douta on a write cycle: WRITE_FIRST / READ_FIRST / NO_CHANGE
//   INIT_SEL     power-up image: INIT_MAT_A / INIT_MAT_B / INIT_ZERO
// Ports:
//   clka    in  rising-edge clock
//   rsta_n  in  asynchronous active-low reset (clears output stages only)
//   ena     in  port enable; low = no read, no write, outputs hold
//   wea     in  write enable, qualified by ena
//   addra   in  word address
//   dina    in  write data
//   douta   out read data
// ----------------------------------------------------------------------------
module matrix_bram_sp
    import matrix_mem_pkg::*;
#(
    parameter int          DATA_W       = DATA_W_DEF,
    parameter int          ADDR_W       = ADDR_W_DEF,
    parameter int          READ_LATENCY = 1,
    parameter write_mode_e WRITE_MODE   = WRITE_FIRST,
    parameter init_sel_e   INIT_SEL     = INIT_MAT_A
) (
    input  logic              clka,
    input  logic              rsta_n,
    input  logic              ena,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    output logic [DATA_W-1:0] douta
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef logic [DEPTH-1:0][DATA_W-1:0] image_t;

    // Build the power-up image at elaboration; words beyond the 16-entry
    // package tables start at zero when the RAM is made deeper.
    function automatic image_t build_image();
        image_t img;
        img = '0;
        for (int i = 0; i < DEPTH && i < MAT_DEPTH; i++) begin
            img[i] = DATA_W'(init_byte(INIT_SEL, i));
        end
        return img;
    endfunction

    localparam image_t INIT_IMAGE = build_image();

    // The array carries its power-up contents as a declaration initialiser,
    // so reset never touches it.
    image_t            mem_q = INIT_IMAGE;

    logic              wr_en;
    logic [DATA_W-1:0] rd_d;
    logic [DATA_W-1:0] rd_q;

    // First read stage: what douta (or the output register input) should
    // become at the next edge, given enable, write and the write mode.
    always_comb begin
        rd_d  = rd_q;
        wr_en = ena & wea;
        if (ena) begin
            if (wea) begin
                case (WRITE_MODE)
                    WRITE_FIRST: rd_d = dina;
                    READ_FIRST:  rd_d = mem_q[addra];
                    default:     rd_d = rd_q;
                endcase
            end else begin
                rd_d = mem_q[addra];
            end
        end
    end

    // First read stage register, cleared asynchronously by reset.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    // Array write port; deliberately outside the reset so contents survive.
    always_ff @(posedge clka) begin
        if (wr_en) begin
            mem_q[addra] <= dina;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_out_reg
            logic [DATA_W-1:0] out_data;

            bram_out_reg #(
                .W (DATA_W)
            ) u_out_reg (
                .clk   (clka),
                .rst_n (rsta_n),
                .en    (ena),
                .d     (rd_q),
                .q     (out_data)
            );

            assign douta = out_data;
        end else begin : g_no_out_reg
            assign douta = rd_q;
        end
    endgenerate

endmodule

// File: tb/tb_matrix_bram_sp.sv
// ----------------------------------------------------------------------------
// tb_matrix_bram_sp
// Four matrix_bram_sp instances share one stimulus stream:
//   0: MAT_A, WRITE_FIRST, latency 1
//   1: MAT_B, READ_FIRST,  latency 1
//   2: MAT_A, NO_CHANGE,   latency 1
//   3: MAT_A, WRITE_FIRST, latency 2
// A behavioural model pushes the expected douta of every instance to a
// scoreboard queue each cycle; the scenario tasks pop and compare, and
// add literal checks for the values the matrix layout dictates.
// ----------------------------------------------------------------------------
module tb_matrix_bram_sp;
    import matrix_mem_pkg::*;

    typedef logic [3:0][7:0] sb_entry_t;

    logic       clk;
    logic       rsta_n;
    logic       ena;
    logic       wea;
    logic [3:0] addra;
    logic [7:0] dina;
    logic [7:0] douta_a, douta_b, douta_n, douta_p;
    logic [7:0] obs [4];

    int         n_assert;
    int         n_fail;

    sb_entry_t  sb_q [$];
    sb_entry_t  exp_v;

    logic [7:0] m_mem [4][16];
    logic [7:0] m_rd  [4];
    logic [7:0] m_out [4];
    int         m_mode [4];
    bit         m_rl2 [4];
    string      dut_name [4];

    assign obs[0] = douta_a;
    assign obs[1] = douta_b;
    assign obs[2] = douta_n;
    assign obs[3] = douta_p;

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    matrix_bram_sp #(.READ_LATENCY(1), .WRITE_MODE(WRITE_FIRST), .INIT_SEL(INIT_MAT_A)) dut_a (
        .clka(clk), .rsta_n(rsta_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta_a));
    matrix_bram_sp #(.READ_LATENCY(1), .WRITE_MODE(READ_FIRST), .INIT_SEL(INIT_MAT_B)) dut_b (
        .clka(clk), .rsta_n(rsta_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta_b));
    matrix_bram_sp #(.READ_LATENCY(1), .WRITE_MODE(NO_CHANGE), .INIT_SEL(INIT_MAT_A)) dut_n (
        .clka(clk), .rsta_n(rsta_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta_n));
    matrix_bram_sp #(.READ_LATENCY(2), .WRITE_MODE(WRITE_FIRST), .INIT_SEL(INIT_MAT_A)) dut_p (
        .clka(clk), .rsta_n(rsta_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta_p));

    // Model setup: mode 0 = write-first, 1 = read-first, 2 = no-change.
    task automatic model_init();
        for (int d = 0; d < 4; d++) begin
            for (int i = 0; i < 16; i++) begin
                if (i >= 1 && i <= 9) m_mem[d][i] = (d == 1) ? 8'(10 - i) : 8'(i);
                else                  m_mem[d][i] = 8'd0;
            end
            m_rd[d]  = 8'd0;
            m_out[d] = 8'd0;
        end
        m_mode   = '{0, 1, 2, 0};
        m_rl2    = '{1'b0, 1'b0, 1'b0, 1'b1};
        dut_name = '{"A_WF", "B_RF", "A_NC", "A_RL2"};
    endtask

    // Drive one clock of stimulus, advance the model and push expectations.
    task automatic do_cycle(input logic en, input logic we, input logic [3:0] addr, input logic [7:0] din);
        sb_entry_t e;
        logic [7:0] nrd;
        @(negedge clk);
        ena   = en;
        wea   = we;
        addra = addr;
        dina  = din;
        @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            if (en) begin
                nrd = m_mem[d][addr];
                if (we) begin
                    if (m_mode[d] == 0)      nrd = din;
                    else if (m_mode[d] == 2) nrd = m_rd[d];
                    m_mem[d][addr] = din;
                end
                m_out[d] = m_rd[d];
                m_rd[d]  = nrd;
            end
            e[d] = m_rl2[d] ? m_out[d] : m_rd[d];
        end
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        @(negedge clk);
        ena   = 1'b1;
        addra = 4'd1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 4; d++) begin
                n_assert++;
                if (obs[d] !== 8'h00) begin
                    n_fail++;
                    $display("[TB] FAIL reset %s cycle %0d: douta=%h expected=00", dut_name[d], c, obs[d]);
                end
            end
        end
        @(negedge clk);
        ena    = 1'b0;
        rsta_n = 1'b1;
    endtask

    task automatic test_powerup_sweep();
        for (int a = 0; a < 16; a++) begin
            do_cycle(1'b1, 1'b0, 4'(a), 8'h00);
            exp_v = sb_q.pop_front();
            for (int d = 0; d < 4; d++) begin
                n_assert++;
                if (obs[d] !== exp_v[d]) begin
                    n_fail++;
                    $display("[TB] FAIL sweep addr %0d %s: douta=%h expected=%h", a, dut_name[d], obs[d], exp_v[d]);
                end
            end
            if (a >= 1 && a <= 9) begin
                n_assert++;
                if (douta_b !== 8'(10 - a)) begin
                    n_fail++;
                    $display("[TB] FAIL sweep MAT_B addr %0d: douta=%h expected=%h", a, douta_b, 8'(10 - a));
                end
            end
        end
    endtask

    task automatic test_write_first();
        do_cycle(1'b1, 1'b1, 4'd3, 8'hA5);
        n_assert++;
        if (douta_a !== 8'hA5) begin
            n_fail++;
            $display("[TB] FAIL write_first same cycle: douta=%h expected=a5", douta_a);
        end
        exp_v = sb_q.pop_front();
        do_cycle(1'b1, 1'b0, 4'd3, 8'h00);
        exp_v = sb_q.pop_front();
        for (int d = 0; d < 4; d++) begin
            n_assert++;
            if (obs[d] !== exp_v[d]) begin
                n_fail++;
                $display("[TB] FAIL write_first readback %s: douta=%h expected=%h", dut_name[d], obs[d], exp_v[d]);
            end
        end
        n_assert++;
        if (douta_a !== 8'hA5) begin
            n_fail++;
            $display("[TB] FAIL write_first readback literal: douta=%h expected=a5", douta_a);
        end
    endtask

    task automatic test_read_first_no_change();
        logic       we_t  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [3:0] adr_t [5] = '{4'd5, 4'd12, 4'd12, 4'd5, 4'd5};
        logic [7:0] din_t [5] = '{8'h06, 8'h11, 8'h00, 8'h3C, 8'h00};
        for (int s = 0; s < 5; s++) begin
            do_cycle(1'b1, we_t[s], adr_t[s], din_t[s]);
            exp_v = sb_q.pop_front();
            for (int d = 0; d < 4; d++) begin
                n_assert++;
                if (obs[d] !== exp_v[d]) begin
                    n_fail++;
                    $display("[TB] FAIL rf_nc step %0d %s: douta=%h expected=%h", s, dut_name[d], obs[d], exp_v[d]);
                end
            end
            if (s == 3) begin
                n_assert += 2;
                if (douta_b !== 8'h06) begin
                    n_fail++;
                    $display("[TB] FAIL read_first old data: douta=%h expected=06", douta_b);
                end
                if (douta_n !== 8'h11) begin
                    n_fail++;
                    $display("[TB] FAIL no_change hold: douta=%h expected=11", douta_n);
                end
            end
            if (s == 4) begin
                n_assert += 3;
                if (douta_a !== 8'h3C) begin n_fail++; $display("[TB] FAIL readback A_WF: douta=%h expected=3c", douta_a); end
                if (douta_b !== 8'h3C) begin n_fail++; $display("[TB] FAIL readback B_RF: douta=%h expected=3c", douta_b); end
                if (douta_n !== 8'h3C) begin n_fail++; $display("[TB] FAIL readback A_NC: douta=%h expected=3c", douta_n); end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_cycle(1'b1, 1'b1, 4'd10, 8'h5A);
        exp_v = sb_q.pop_front();
        for (int r = 0; r < 2; r++) begin
            do_cycle(1'b1, 1'b0, 4'd10, 8'h00);
            exp_v = sb_q.pop_front();
            for (int d = 0; d < 4; d++) begin
                n_assert++;
                if (obs[d] !== exp_v[d]) begin
                    n_fail++;
                    $display("[TB] FAIL back_to_back read %0d %s: douta=%h expected=%h", r, dut_name[d], obs[d], exp_v[d]);
                end
            end
        end
        n_assert++;
        if (douta_p !== 8'h5A) begin
            n_fail++;
            $display("[TB] FAIL back_to_back latency2: douta=%h expected=5a", douta_p);
        end
    endtask

    task automatic test_enable_gating();
        logic       en_t  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic       we_t  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0] adr_t [6] = '{4'd8, 4'd9, 4'd2, 4'd2, 4'd2, 4'd2};
        logic [7:0] din_t [6] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00};
        for (int s = 0; s < 6; s++) begin
            do_cycle(en_t[s], we_t[s], adr_t[s], din_t[s]);
            exp_v = sb_q.pop_front();
            for (int d = 0; d < 4; d++) begin
                n_assert++;
                if (obs[d] !== exp_v[d]) begin
                    n_fail++;
                    $display("[TB] FAIL gating step %0d %s: douta=%h expected=%h", s, dut_name[d], obs[d], exp_v[d]);
                end
            end
            if (s == 3) begin
                n_assert += 2;
                if (douta_a !== 8'h09) begin n_fail++; $display("[TB] FAIL gating hold: douta=%h expected=09", douta_a); end
                if (douta_p !== 8'h08) begin n_fail++; $display("[TB] FAIL gating pipeline freeze: douta=%h expected=08", douta_p); end
            end
            if (s == 4) begin
                n_assert++;
                if (douta_a !== 8'h02) begin n_fail++; $display("[TB] FAIL gating mem[2] kept: douta=%h expected=02", douta_a); end
            end
        end
    endtask

    task automatic test_async_reset();
        for (int r = 0; r < 2; r++) begin
            do_cycle(1'b1, 1'b0, 4'd7, 8'h00);
            exp_v = sb_q.pop_front();
        end
        n_assert++;
        if (douta_a !== 8'h07) begin
            n_fail++;
            $display("[TB] FAIL pre-reset read: douta=%h expected=07", douta_a);
        end
        #2;
        rsta_n = 1'b0;
        #1;
        for (int d = 0; d < 4; d++) begin
            n_assert++;
            if (obs[d] !== 8'h00) begin
                n_fail++;
                $display("[TB] FAIL async clear %s: douta=%h expected=00", dut_name[d], obs[d]);
            end
            m_rd[d]  = 8'd0;
            m_out[d] = 8'd0;
        end
        @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        rsta_n = 1'b1;
        for (int r = 0; r < 2; r++) begin
            do_cycle(1'b1, 1'b0, 4'd7, 8'h00);
            exp_v = sb_q.pop_front();
            for (int d = 0; d < 4; d++) begin
                n_assert++;
                if (obs[d] !== exp_v[d]) begin
                    n_fail++;
                    $display("[TB] FAIL post-reset read %0d %s: douta=%h expected=%h", r, dut_name[d], obs[d], exp_v[d]);
                end
            end
        end
        n_assert++;
        if (douta_a !== 8'h07) begin
            n_fail++;
            $display("[TB] FAIL array preserved: douta=%h expected=07", douta_a);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] adr_t [3] = '{4'd15, 4'd0, 4'd1};
        logic [7:0] lit_t [3] = '{8'h00, 8'h00, 8'h01};
        for (int s = 0; s < 3; s++) begin
            do_cycle(1'b1, 1'b0, adr_t[s], 8'h00);
            exp_v = sb_q.pop_front();
            for (int d = 0; d < 4; d++) begin
                n_assert++;
                if (obs[d] !== exp_v[d]) begin
                    n_fail++;
                    $display("[TB] FAIL wrap step %0d %s: douta=%h expected=%h", s, dut_name[d], obs[d], exp_v[d]);
                end
            end
            n_assert++;
            if (douta_a !== lit_t[s]) begin
                n_fail++;
                $display("[TB] FAIL wrap literal addr %0d: douta=%h expected=%h", adr_t[s], douta_a, lit_t[s]);
            end
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rsta_n   = 1'b0;
        ena      = 1'b0;
        wea      = 1'b0;
        addra    = 4'd0;
        dina     = 8'd0;
        model_init();

        test_reset();
        test_powerup_sweep();
        test_write_first();
        test_read_first_no_change();
        test_back_to_back();
        test_enable_gating();
        test_async_reset();
        test_wrap();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
